// File: rtl/adc_bcd_display_feed.sv
// adc_bcd_display_feed: captures ADC samples on DATA_VALID rising edges and feeds seg7_control with BCD digits
// Build option: define ADC_AVG_EN to block-average 2**AVG_LOG2 accepted samples before conversion.
// Ports: clk; reset (sync, active-high); i_DATA / i_DATA_VALID sample input (one accept per valid rising edge);
//        ones/tens/hundreds/thousands BCD digits; o_BUSY conversion running; o_DONE digits updated (1 cycle);
//        o_OVERRUN pending sample overwritten (1 cycle).
module adc_bcd_display_feed #(
  parameter int DATA_W   = 12,
  parameter int AVG_LOG2 = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] i_DATA,
  input  logic              i_DATA_VALID,
  output logic [3:0]        ones,
  output logic [3:0]        tens,
  output logic [3:0]        hundreds,
  output logic [3:0]        thousands,
  output logic              o_BUSY,
  output logic              o_DONE,
  output logic              o_OVERRUN
);
  localparam int CW = $clog2(DATA_W + 1);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t            state_q, state_d;
  logic              vprev_q, accept, take;
  logic [DATA_W-1:0] samp, sr_q, sr_d, pend_q, pend_d;
  logic [15:0]       bcd_q, bcd_d, adj, dig_q, dig_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              pflag_q, pflag_d, done_q, done_d, ovr_q, ovr_d;

  if (DATA_W < 1 || DATA_W > 13 || AVG_LOG2 < 1) begin : g_bad_param
    $error("adc_bcd_display_feed: DATA_W must be 1..13 and AVG_LOG2 >= 1");
  end

  assign accept = i_DATA_VALID & ~vprev_q;

`ifdef ADC_AVG_EN
  logic [DATA_W+AVG_LOG2-1:0] acc_q, acc_d, sum;
  logic [AVG_LOG2-1:0]        acnt_q, acnt_d;
  // only the accept that completes a block reaches the conversion path
  always_comb begin
    sum    = acc_q + (DATA_W+AVG_LOG2)'(i_DATA);
    take   = accept & (&acnt_q);
    samp   = DATA_W'(sum >> AVG_LOG2);
    acc_d  = accept ? (take ? '0 : sum) : acc_q;
    acnt_d = accept ? acnt_q + AVG_LOG2'(1) : acnt_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q  <= '0;
      acnt_q <= '0;
    end else begin
      acc_q  <= acc_d;
      acnt_q <= acnt_d;
    end
  end
`else
  assign take = accept;
  assign samp = i_DATA;
`endif

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    dig_d   = dig_q;
    pend_d  = pend_q;
    pflag_d = pflag_q;
    done_d  = 1'b0;
    ovr_d   = 1'b0;
    for (int i = 0; i < 4; i++)
      adj[4*i +: 4] = bcd_q[4*i +: 4] >= 4'd5 ? bcd_q[4*i +: 4] + 4'd3 : bcd_q[4*i +: 4];
    case (state_q)
      IDLE: if (take) begin
        state_d = SHIFT;
        sr_d    = samp;
        bcd_d   = '0;
        cnt_d   = '0;
      end
      SHIFT: begin
        {bcd_d, sr_d} = {adj, sr_q} << 1;
        cnt_d   = cnt_q + CW'(1);
        state_d = cnt_q == CW'(DATA_W - 1) ? DONE : SHIFT;
        if (take) begin
          pend_d  = samp;
          pflag_d = 1'b1;
          ovr_d   = pflag_q;
        end
      end
      DONE: begin
        // a queued sample takes priority; a same-cycle accept then becomes the new pending one
        dig_d   = bcd_q;
        done_d  = 1'b1;
        state_d = pflag_q || take ? SHIFT : IDLE;
        sr_d    = pflag_q ? pend_q : samp;
        bcd_d   = '0;
        cnt_d   = '0;
        pflag_d = pflag_q & take;
        pend_d  = pflag_q && take ? samp : pend_q;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      vprev_q <= 1'b0;
      sr_q    <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      dig_q   <= '0;
      pend_q  <= '0;
      pflag_q <= 1'b0;
      done_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      vprev_q <= i_DATA_VALID;
      sr_q    <= sr_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      dig_q   <= dig_d;
      pend_q  <= pend_d;
      pflag_q <= pflag_d;
      done_q  <= done_d;
      ovr_q   <= ovr_d;
    end
  end

  assign {thousands, hundreds, tens, ones} = dig_q;
  assign o_BUSY    = state_q != IDLE;
  assign o_DONE    = done_q;
  assign o_OVERRUN = ovr_q;
endmodule

// File: tb/tb_adc_bcd_display_feed.sv
// tb_adc_bcd_display_feed: table, corner-sequence and randomized checks against a timestamp-based model
module tb_adc_bcd_display_feed;
  localparam int DW = 12;
  localparam int AL = 2;
`ifdef ADC_AVG_EN
  localparam int NACC = 1 << AL;
`else
  localparam int NACC = 1;
`endif

  logic          clk = 1'b0, reset = 1'b1, i_DATA_VALID = 1'b0;
  logic [DW-1:0] i_DATA = '0;
  logic [3:0]    ones, tens, hundreds, thousands;
  logic          o_BUSY, o_DONE, o_OVERRUN;
  int            n_cmp = 0, n_bad = 0;

  adc_bcd_display_feed #(.DATA_W(DW), .AVG_LOG2(AL)) dut (
    .clk(clk), .reset(reset), .i_DATA(i_DATA), .i_DATA_VALID(i_DATA_VALID),
    .ones(ones), .tens(tens), .hundreds(hundreds), .thousands(thousands),
    .o_BUSY(o_BUSY), .o_DONE(o_DONE), .o_OVERRUN(o_OVERRUN)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Model: a conversion started at edge e finishes at edge e+DW+1; one pending slot.
  int m_edge = 0, m_done_at = 0, m_cur = 0, m_pend = 0, m_disp = 0, m_acc = 0, m_acnt = 0;
  bit m_act = 0, m_pf = 0, m_done = 0, m_ovr = 0, m_vprev = 0;

  function automatic logic [15:0] bcd(input int x);
    return {4'(x / 1000 % 10), 4'(x / 100 % 10), 4'(x / 10 % 10), 4'(x % 10)};
  endfunction

  function automatic void m_start(input int x);
    m_act = 1; m_cur = x; m_done_at = m_edge + DW + 1;
  endfunction

  function automatic void model_edge(input bit r, input bit v, input int d);
    bit acc_ok, tk;
    int val;
    m_done = 0; m_ovr = 0;
    if (r) begin
      m_act = 0; m_pf = 0; m_disp = 0; m_vprev = 0; m_acc = 0; m_acnt = 0;
    end else begin
      acc_ok = v && !m_vprev;
      m_vprev = v;
      tk = acc_ok; val = d;
`ifdef ADC_AVG_EN
      if (acc_ok) begin
        m_acc += d; m_acnt++;
        tk = (m_acnt == NACC);
        if (tk) begin val = m_acc >> AL; m_acc = 0; m_acnt = 0; end
      end
`endif
      if (m_act && m_edge == m_done_at) begin
        m_disp = m_cur; m_done = 1;
        if (m_pf) begin m_start(m_pend); m_pf = tk; m_pend = val; end
        else if (tk) m_start(val);
        else m_act = 0;
      end else if (!m_act) begin
        if (tk) m_start(val);
      end else if (tk) begin
        m_ovr = m_pf; m_pf = 1; m_pend = val;
      end
    end
    m_edge++;
  endfunction

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  int sd_n = 0, so_n = 0, s_gap = 0;
  logic [15:0] dq[$];

  task automatic step(input logic r, input logic v, input logic [DW-1:0] d);
    reset = r; i_DATA_VALID = v; i_DATA = d;
    @(posedge clk);
    model_edge(r, v, int'(d));
    #1;
    cmp("o_DONE", 32'(o_DONE), 32'(m_done));
    cmp("o_BUSY", 32'(o_BUSY), 32'(m_act));
    cmp("o_OVERRUN", 32'(o_OVERRUN), 32'(m_ovr));
    cmp("digits", 32'({thousands, hundreds, tens, ones}), 32'(bcd(m_disp)));
    if (o_DONE) begin sd_n++; dq.push_back({thousands, hundreds, tens, ones}); end
    if (o_OVERRUN) so_n++;
    if (!o_BUSY && !o_DONE) s_gap++;
  endtask

  task automatic pulse(input logic [DW-1:0] d);
    step(0, 1, d);
    step(0, 0, d);
  endtask

  task automatic wait_done(output int lat);
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      step(0, 0, '0);
      if (o_DONE) begin lat = i; break; end
    end
  endtask

  typedef struct { int d; logic [15:0] exp; } vec_t;
  vec_t vt[7];

  initial begin
    int lat;
    vt[0] = '{4095, 16'h4095};
    vt[1] = '{0,    16'h0000};
    vt[2] = '{1000, 16'h1000};
    vt[3] = '{123,  16'h0123};
    vt[4] = '{9,    16'h0009};
    vt[5] = '{999,  16'h0999};
    vt[6] = '{2048, 16'h2048};

    repeat (3) step(1, 0, '0);
    step(0, 0, '0);
    cmp("reset digits", 32'({thousands, hundreds, tens, ones}), 32'h0);
    cmp("reset busy", 32'(o_BUSY), 32'h0);

    for (int i = 0; i < 7; i++) begin
      for (int j = 0; j < NACC - 1; j++) pulse(DW'(vt[i].d));
      step(0, 1, DW'(vt[i].d));
      wait_done(lat);
      cmp("table latency", 32'(lat), 32'(DW + 1));
      cmp("table digits", 32'({thousands, hundreds, tens, ones}), 32'(vt[i].exp));
    end

`ifndef ADC_AVG_EN
    sd_n = 0;
    repeat (20) step(0, 1, 12'd123);
    repeat (20) step(0, 0, '0);
    cmp("held dones", 32'(sd_n), 32'd1);
    cmp("held digits", 32'({thousands, hundreds, tens, ones}), 32'h0123);

    sd_n = 0; so_n = 0; s_gap = 0; dq.delete();
    pulse(12'd44); pulse(12'd11); pulse(12'd22); pulse(12'd33);
    for (int i = 0; i < 60 && sd_n < 2; i++) step(0, 0, '0);
    cmp("pend dones", 32'(sd_n), 32'd2);
    cmp("pend conv1", 32'(dq.size() > 0 ? dq[0] : 16'hffff), 32'h0044);
    cmp("pend conv2", 32'(dq.size() > 1 ? dq[1] : 16'hffff), 32'h0033);
    cmp("pend overruns", 32'(so_n), 32'd2);
    cmp("pend idle gap", 32'(s_gap), 32'd0);

    pulse(12'd500);
    repeat (4) step(0, 0, '0);
    step(1, 0, '0);
    cmp("midrst done", 32'(o_DONE), 32'h0);
    cmp("midrst busy", 32'(o_BUSY), 32'h0);
    cmp("midrst digits", 32'({thousands, hundreds, tens, ones}), 32'h0);
    step(0, 0, '0);
    step(0, 1, 12'd77);
    wait_done(lat);
    cmp("post-rst latency", 32'(lat), 32'(DW + 1));
    cmp("post-rst digits", 32'({thousands, hundreds, tens, ones}), 32'h0077);
`else
    sd_n = 0;
    step(0, 0, '0);
    pulse(12'd100); pulse(12'd200); pulse(12'd300);
    step(0, 1, 12'd401);
    wait_done(lat);
    cmp("avg latency", 32'(lat), 32'(DW + 1));
    cmp("avg digits", 32'({thousands, hundreds, tens, ones}), 32'h0250);
    cmp("avg dones", 32'(sd_n), 32'd1);
`endif

    for (int i = 0; i < 3000; i++)
      step(logic'($urandom_range(0, 399) == 0), logic'($urandom_range(0, 2) == 0), DW'($urandom_range(0, 4095)));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
